// File: rtl/svc_soc_lifecycle_pkg.sv
// Shared types for the SoC lifecycle monitor: run-state encoding and reported status codes.
package svc_soc_lifecycle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_PASS    = 2'd1,
    STATUS_FAIL    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } status_t;

endpackage

// File: rtl/svc_idle_counter.sv
// Single-channel idle counter: clears on activity, saturates at the last count, and flags
// expiry when an enabled channel sits at the last count with no activity this cycle.
module svc_idle_counter
  import svc_soc_lifecycle_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic activity,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(WATCHDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating at the last count keeps masked channels from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || activity) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !activity && (cnt_q == CNT_LAST);

endmodule

// File: rtl/svc_soc_lifecycle_mon.sv
// Multi-channel run lifecycle monitor: software exit, per-channel idle watchdog, global cycle limit.
// Optional liveness toggle on heartbeat enabled by SVC_SOC_LIFECYCLE_MON_HEARTBEAT_EN.
module svc_soc_lifecycle_mon
  import svc_soc_lifecycle_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned WATCHDOG_CYCLES = 500_000,
  parameter int unsigned MAX_CYCLES      = 0,
  parameter int unsigned CODE_W          = 8,
  parameter int unsigned CYC_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] activity,
  input  logic              exit_valid,
  input  logic [CODE_W-1:0] exit_code,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [CODE_W-1:0] code_q,
  output logic [NUM_CH-1:0] timeout_ch,
  output logic              limit_hit,
  output logic [CYC_W-1:0]  cycles,
  output logic              heartbeat
);

  localparam bit LIMIT_EN = (MAX_CYCLES != 0);
  localparam logic [CYC_W-1:0] LIMIT_LAST = LIMIT_EN ? CYC_W'(MAX_CYCLES - 1) : '0;

  state_t              state_q, state_d;
  status_t             status_q, status_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CODE_W-1:0]   exit_code_q, exit_code_d;
  logic [NUM_CH-1:0]   tch_q, tch_d;
  logic                limit_q, limit_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;
  logic                running_q, running_d;
  logic                done_q, done_d;

  logic                in_run_c, start_run_c, limit_now_c;
  logic [NUM_CH-1:0]   expire_c;

  assign in_run_c    = (state_q == RUN);
  assign start_run_c = (state_q == IDLE) && start;
  assign limit_now_c = LIMIT_EN && (cycles_q == LIMIT_LAST);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    svc_idle_counter #(
      .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_idle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_run_c),
      .en       (mask_q[i] && in_run_c),
      .activity (activity[i]),
      .expire   (expire_c[i])
    );
  end

  // Next-state and registered-output logic; exit beats any timeout on the same cycle.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    mask_d      = mask_q;
    exit_code_d = exit_code_q;
    tch_d       = tch_q;
    limit_d     = limit_q;
    cycles_d    = cycles_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          status_d    = STATUS_NONE;
          mask_d      = ch_mask;
          exit_code_d = '0;
          tch_d       = '0;
          limit_d     = 1'b0;
          cycles_d    = '0;
        end
      end
      RUN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
        if (exit_valid) begin
          exit_code_d = exit_code;
          if (exit_code == '0) begin
            state_d  = PASS;
            status_d = STATUS_PASS;
          end else begin
            state_d  = FAIL;
            status_d = STATUS_FAIL;
          end
        end else if ((|expire_c) || limit_now_c) begin
          state_d  = TIMEOUT;
          status_d = STATUS_TIMEOUT;
          tch_d    = expire_c;
          limit_d  = limit_now_c;
        end
      end
      PASS, FAIL, TIMEOUT: begin
        if (clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      status_q    <= STATUS_NONE;
      mask_q      <= '0;
      exit_code_q <= '0;
      tch_q       <= '0;
      limit_q     <= 1'b0;
      cycles_q    <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      mask_q      <= mask_d;
      exit_code_q <= exit_code_d;
      tch_q       <= tch_d;
      limit_q     <= limit_d;
      cycles_q    <= cycles_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign running    = running_q;
  assign done       = done_q;
  assign status     = status_q;
  assign code_q     = exit_code_q;
  assign timeout_ch = tch_q;
  assign limit_hit  = limit_q;
  assign cycles     = cycles_q;

`ifdef SVC_SOC_LIFECYCLE_MON_HEARTBEAT_EN
  localparam int unsigned HB_BIT = (CYC_W > 16) ? 15 : CYC_W - 1;

  logic hb_q, hb_d;

  // Toggle on each falling edge of the chosen cycle bit, i.e. once per 2^16 RUN cycles.
  always_comb begin
    hb_d = hb_q;
    if (in_run_c && cycles_q[HB_BIT] && !cycles_d[HB_BIT]) begin
      hb_d = ~hb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= hb_d;
    end
  end

  assign heartbeat = hb_q;
`else
  assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_svc_soc_lifecycle_mon.sv
// Bench for svc_soc_lifecycle_mon: scenario table with scoreboard plus hand-written corner sequences.
module tb_svc_soc_lifecycle_mon;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WD     = 16;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned CYC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, clear, exit_valid;
  logic [NUM_CH-1:0] ch_mask, activity;
  logic [CODE_W-1:0] exit_code;

  logic              d_running, d_done, d_lim, d_hb;
  logic [1:0]        d_status;
  logic [CODE_W-1:0] d_code;
  logic [NUM_CH-1:0] d_tch;
  logic [CYC_W-1:0]  d_cycles;

  logic              l_running, l_done, l_lim, l_hb;
  logic [1:0]        l_status;
  logic [CODE_W-1:0] l_code;
  logic [NUM_CH-1:0] l_tch;
  logic [CYC_W-1:0]  l_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  svc_soc_lifecycle_mon #(
    .NUM_CH(NUM_CH), .WATCHDOG_CYCLES(WD), .MAX_CYCLES(0), .CODE_W(CODE_W), .CYC_W(CYC_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .ch_mask(ch_mask),
    .activity(activity), .exit_valid(exit_valid), .exit_code(exit_code),
    .running(d_running), .done(d_done), .status(d_status), .code_q(d_code),
    .timeout_ch(d_tch), .limit_hit(d_lim), .cycles(d_cycles), .heartbeat(d_hb)
  );

  svc_soc_lifecycle_mon #(
    .NUM_CH(NUM_CH), .WATCHDOG_CYCLES(WD), .MAX_CYCLES(50), .CODE_W(CODE_W), .CYC_W(CYC_W)
  ) u_lim (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .ch_mask(ch_mask),
    .activity(activity), .exit_valid(exit_valid), .exit_code(exit_code),
    .running(l_running), .done(l_done), .status(l_status), .code_q(l_code),
    .timeout_ch(l_tch), .limit_hit(l_lim), .cycles(l_cycles), .heartbeat(l_hb)
  );

  typedef struct {
    logic [1:0] mask;
    int         p0;
    int         p1;
    int         p1_stop;
    int         exit_at;
    logic [7:0] code;
    int         max_len;
    bit         sel_lim;
    logic [1:0] e_status;
    logic [7:0] e_code;
    logic [1:0] e_tch;
    logic       e_lim;
    int         e_cycles;
    logic       e_running;
    logic       e_done;
  } scn_t;

  scn_t tbl[12];
  scn_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m);
    @(negedge clk);
    start   = 1'b1;
    ch_mask = m;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic cleanup();
    activity   = '0;
    exit_valid = 1'b1;
    exit_code  = '0;
    @(negedge clk);
    exit_valid = 1'b0;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int   n;
    bit   fin;
    scn_t e;
    sb_q.push_back(s);
    start_run(s.mask);
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      n++;
      activity[0] = (s.p0 > 0) ? ((n % s.p0) == 0) : 1'b0;
      activity[1] = (s.p1 > 0 && n <= s.p1_stop) ? ((n % s.p1) == 0) : 1'b0;
      exit_valid  = (n == s.exit_at);
      exit_code   = s.code;
      @(negedge clk);
      if ((s.sel_lim ? l_done : d_done) || n >= s.max_len) fin = 1'b1;
    end
    activity   = '0;
    exit_valid = 1'b0;
    e = sb_q.pop_front();
    if (e.sel_lim) begin
      chk($sformatf("s%0d.status", idx),  32'(l_status),  32'(e.e_status));
      chk($sformatf("s%0d.code", idx),    32'(l_code),    32'(e.e_code));
      chk($sformatf("s%0d.tch", idx),     32'(l_tch),     32'(e.e_tch));
      chk($sformatf("s%0d.limit", idx),   32'(l_lim),     32'(e.e_lim));
      chk($sformatf("s%0d.cycles", idx),  l_cycles,       32'(e.e_cycles));
      chk($sformatf("s%0d.running", idx), 32'(l_running), 32'(e.e_running));
      chk($sformatf("s%0d.done", idx),    32'(l_done),    32'(e.e_done));
      chk($sformatf("s%0d.hb", idx),      32'(l_hb),      32'(0));
    end else begin
      chk($sformatf("s%0d.status", idx),  32'(d_status),  32'(e.e_status));
      chk($sformatf("s%0d.code", idx),    32'(d_code),    32'(e.e_code));
      chk($sformatf("s%0d.tch", idx),     32'(d_tch),     32'(e.e_tch));
      chk($sformatf("s%0d.limit", idx),   32'(d_lim),     32'(e.e_lim));
      chk($sformatf("s%0d.cycles", idx),  d_cycles,       32'(e.e_cycles));
      chk($sformatf("s%0d.running", idx), 32'(d_running), 32'(e.e_running));
      chk($sformatf("s%0d.done", idx),    32'(d_done),    32'(e.e_done));
      chk($sformatf("s%0d.hb", idx),      32'(d_hb),      32'(0));
    end
    cleanup();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    // mask p0 p1 p1_stop exit code max sel | status code tch lim cycles running done
    tbl[0]  = '{2'b11, 4, 4,  1000, 40, 8'h00,  60, 1'b0, 2'd1, 8'h00, 2'b00, 1'b0, 40,  1'b0, 1'b1};
    tbl[1]  = '{2'b11, 4, 4,  1000, 40, 8'h2A,  60, 1'b0, 2'd2, 8'h2A, 2'b00, 1'b0, 40,  1'b0, 1'b1};
    tbl[2]  = '{2'b11, 4, 0,  1000,  0, 8'h00,  60, 1'b0, 2'd3, 8'h00, 2'b10, 1'b0, 16,  1'b0, 1'b1};
    tbl[3]  = '{2'b01, 4, 0,  1000,  0, 8'h00, 100, 1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 100, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, 4, 16, 1000, 40, 8'h00,  60, 1'b0, 2'd1, 8'h00, 2'b00, 1'b0, 40,  1'b0, 1'b1};
    tbl[5]  = '{2'b11, 4, 17, 1000,  0, 8'h00,  60, 1'b0, 2'd3, 8'h00, 2'b10, 1'b0, 16,  1'b0, 1'b1};
    tbl[6]  = '{2'b11, 4, 0,  1000, 16, 8'h00,  60, 1'b0, 2'd1, 8'h00, 2'b00, 1'b0, 16,  1'b0, 1'b1};
    tbl[7]  = '{2'b11, 0, 0,  1000,  0, 8'h00,  60, 1'b0, 2'd3, 8'h00, 2'b11, 1'b0, 16,  1'b0, 1'b1};
    tbl[8]  = '{2'b10, 0, 4,  1000, 30, 8'h05,  60, 1'b0, 2'd2, 8'h05, 2'b00, 1'b0, 30,  1'b0, 1'b1};
    tbl[9]  = '{2'b11, 1, 1,  1000,  0, 8'h00,  60, 1'b1, 2'd3, 8'h00, 2'b00, 1'b1, 50,  1'b0, 1'b1};
    tbl[10] = '{2'b11, 1, 1,    34,  0, 8'h00,  60, 1'b1, 2'd3, 8'h00, 2'b10, 1'b1, 50,  1'b0, 1'b1};
    tbl[11] = '{2'b11, 1, 1,  1000, 50, 8'h07,  60, 1'b1, 2'd2, 8'h07, 2'b00, 1'b0, 50,  1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; exit_valid = 1'b0;
    ch_mask = '0; activity = '0; exit_code = '0;
    repeat (3) @(negedge clk);
    chk("rst.running", 32'(d_running), 32'(0));
    chk("rst.done",    32'(d_done),    32'(0));
    chk("rst.status",  32'(d_status),  32'(0));
    chk("rst.cycles",  d_cycles,       32'(0));
    chk("rst.misc",    32'({d_code, d_tch, d_lim, d_hb}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset in the middle of a run
    start_run(2'b11);
    activity = 2'b11;
    repeat (5) @(negedge clk);
    chk("mid.cycles", d_cycles, 32'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst.running", 32'(d_running), 32'(0));
    chk("arst.cycles",  d_cycles,       32'(0));
    chk("arst.done",    32'(d_done),    32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    activity = '0;
    @(negedge clk);
    chk("arst.idle", 32'(d_running), 32'(0));

    // done timing, start/clear ignored in RUN, sticky terminal, hold after clear
    start_run(2'b11);
    activity = 2'b11;
    start = 1'b1; clear = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("b.running4", 32'(d_running), 32'(1));
    chk("b.done4",    32'(d_done),    32'(0));
    chk("b.cycles4",  d_cycles,       32'(4));
    exit_valid = 1'b1; exit_code = 8'h00;
    @(negedge clk);
    chk("b.done5",    32'(d_done),    32'(1));
    chk("b.running5", 32'(d_running), 32'(0));
    chk("b.status5",  32'(d_status),  32'(1));
    chk("b.cycles5",  d_cycles,       32'(5));
    exit_code = 8'h33; start = 1'b1;
    repeat (3) @(negedge clk);
    exit_valid = 1'b0; start = 1'b0; activity = '0;
    chk("b.sticky_status", 32'(d_status), 32'(1));
    chk("b.sticky_code",   32'(d_code),   32'(0));
    chk("b.sticky_cycles", d_cycles,      32'(5));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("b.clr_done",   32'(d_done),   32'(0));
    chk("b.clr_status", 32'(d_status), 32'(1));
    chk("b.clr_cycles", d_cycles,      32'(5));

    // Fail, clear, restart clears captured code and cycle count
    start_run(2'b11);
    activity = 2'b11;
    repeat (2) @(negedge clk);
    exit_valid = 1'b1; exit_code = 8'h2A;
    @(negedge clk);
    exit_valid = 1'b0;
    chk("c.status", 32'(d_status), 32'(2));
    chk("c.code",   32'(d_code),   32'(8'h2A));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("c.hold_code", 32'(d_code), 32'(8'h2A));
    start_run(2'b11);
    chk("c.re_code",    32'(d_code),    32'(0));
    chk("c.re_status",  32'(d_status),  32'(0));
    chk("c.re_cycles",  d_cycles,       32'(0));
    chk("c.re_running", 32'(d_running), 32'(1));
    repeat (3) @(negedge clk);
    chk("c.re_cycles3", d_cycles, 32'(3));
    cleanup();

    for (int i = 0; i < 12; i++) begin
      run_scn(i, tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
